// File: rtl/clk_div_gen_if.sv
// Configuration write channel for clk_div_gen.
//   cfg_valid  : write request (master -> slave)
//   cfg_ready  : write can be accepted (slave -> master)
//   cfg_ch     : target channel index
//   cfg_div    : new divisor
//   cfg_phase  : new phase
//   cfg_err    : one-cycle pulse when a write targets a non-existent channel
interface clk_div_gen_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable / divided-clock generator with a
// lock indicator that drops whenever any channel is reconfigured.
//   refclk      : sole clock, rising edge
//   reset       : synchronous, active-high
//   ch_enable   : per-channel run enable
//   cfg         : configuration write port (slave side)
//   clk_en      : per-channel one-cycle strobe, once per period
//   clk_div_out : per-channel divided square wave
//   extlock     : configuration has settled for LOCK_CYCLES cycles
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_DIV     = 5,
  parameter int unsigned DEF_PHASE   = 0,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  clk_div_gen_if.slave      cfg,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_div_out,
  output logic              extlock
);

  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [0:0] {StSettle, StLocked} lock_state_e;

  logic [CNT_W-1:0]  div_q     [NUM_CH];
  logic [CNT_W-1:0]  phase_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  period    [NUM_CH];
  logic [CNT_W-1:0]  last      [NUM_CH];
  logic [CNT_W-1:0]  eff_phase [NUM_CH];
  logic [CNT_W-1:0]  half      [NUM_CH];
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] clk_en_q;
  logic [NUM_CH-1:0] clk_div_q;
  logic              cfg_fire;
  logic              cfg_bad;
  logic              cfg_err_q;
  logic              extlock_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  lock_state_e       state_q;

  assign cfg.cfg_ready = ~reset;
  assign cfg_fire      = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_bad       = 32'(cfg.cfg_ch) >= NUM_CH;

  // Divisor 0 behaves as 1; phase beyond the period clamps to the last count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      period[i]    = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];
      last[i]      = period[i] - CNT_W'(1);
      eff_phase[i] = (phase_q[i] > last[i]) ? last[i] : phase_q[i];
      half[i]      = period[i] >> 1;
      cfg_hit[i]   = cfg_fire && (cfg.cfg_ch == 3'(i));
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= CNT_W'(DEF_DIV);
        phase_q[i] <= CNT_W'(DEF_PHASE);
        cnt_q[i]   <= '0;
      end
      clk_en_q  <= '0;
      clk_div_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        clk_en_q[i]  <= ch_enable[i] && (cnt_q[i] == eff_phase[i]);
        clk_div_q[i] <= ch_enable[i] && (cnt_q[i] < half[i]);
        if (cfg_hit[i]) begin
          div_q[i]   <= cfg.cfg_div;
          phase_q[i] <= cfg.cfg_phase;
          cnt_q[i]   <= '0;
        end else if (!ch_enable[i] || (cnt_q[i] >= last[i])) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      cfg_err_q <= cfg_fire && cfg_bad;
    end
  end

  // Lock FSM: a valid write always restarts settling, even on the locking edge.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
      extlock_q  <= 1'b0;
    end else if (cfg_fire && !cfg_bad) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
      extlock_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StSettle: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_q   <= StLocked;
            extlock_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end
        StLocked: begin
          state_q   <= StLocked;
          extlock_q <= 1'b1;
        end
        default: begin
          state_q   <= StSettle;
          extlock_q <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en      = clk_en_q;
  assign clk_div_out = clk_div_q;
  assign extlock     = extlock_q;
  assign cfg.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: stimulus queues expected output bits keyed
// by the rising-edge number after which they must hold; a negedge monitor pops
// and compares them.
module tb_clk_div_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;

  logic              refclk;
  logic              reset;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_div_out;
  logic              extlock;
  int                cyc;
  int                passed;
  int                total;

  localparam int SelEn    = 0;
  localparam int SelDiv   = 1;
  localparam int SelLock  = 2;
  localparam int SelErr   = 3;
  localparam int SelReady = 4;

  typedef struct {
    int    cyc;
    int    sel;
    int    ch;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];

  clk_div_gen_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(5), .DEF_PHASE(0), .LOCK_CYCLES(16)
  ) dut (
    .refclk     (refclk),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .cfg        (cfg_if.slave),
    .clk_en     (clk_en),
    .clk_div_out(clk_div_out),
    .extlock    (extlock)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic get_out(input int sel, input int ch);
    case (sel)
      SelEn:   return clk_en[ch];
      SelDiv:  return clk_div_out[ch];
      SelLock: return extlock;
      SelErr:  return cfg_if.cfg_err;
      default: return cfg_if.cfg_ready;
    endcase
  endfunction

  // Sorted insert keeps the queue ordered by edge number.
  task automatic expect_at(input int c, input int sel, input int ch, input logic v,
                           input string nm);
    exp_t e;
    int   pos;
    e.cyc = c; e.sel = sel; e.ch = ch; e.val = v;
    e.name = $sformatf("%s@%0d", nm, c);
    pos = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc > c) begin
        pos = k;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic expect_ch(input int c, input int ch, input logic en, input logic dv);
    expect_at(c, SelEn, ch, en, $sformatf("ch%0d_clk_en", ch));
    expect_at(c, SelDiv, ch, dv, $sformatf("ch%0d_clk_div_out", ch));
  endtask

  always @(negedge refclk) begin
    exp_t e;
    logic act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      act = get_out(e.sel, e.ch);
      if (e.cyc != cyc) begin
        $display("FAIL %s not sampled (now edge %0d) required %0b", e.name, cyc, e.val);
      end else if (act !== e.val) begin
        $display("FAIL %s actual %0b required %0b", e.name, act, e.val);
      end else begin
        passed++;
      end
    end
  end

  task automatic wait_edge();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) wait_edge();
  endtask

  task automatic do_write(input int ch, input int div, input int phase);
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_div   = CNT_W'(div);
    cfg_if.cfg_phase = CNT_W'(phase);
    cfg_if.cfg_valid = 1'b1;
    wait_edge();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    ch_enable = '1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;

    // Reset state
    wait_edge();
    wait_edge();
    for (int c = 0; c < NUM_CH; c++) expect_ch(2, c, 1'b0, 1'b0);
    expect_at(2, SelLock, 0, 1'b0, "extlock_rst");
    expect_at(2, SelErr, 0, 1'b0, "cfg_err_rst");
    expect_at(2, SelReady, 0, 1'b0, "cfg_ready_rst");

    // Release after edge 3: defaults, period 5, 2 high / 3 low, lock on edge 19
    wait_edge();
    reset = 1'b0;
    expect_at(3, SelReady, 0, 1'b1, "cfg_ready_run");
    for (int n = 4; n <= 18; n++)
      for (int c = 0; c < NUM_CH; c++)
        expect_ch(n, c, ((n - 4) % 5) == 0, ((n - 4) % 5) < 2);
    expect_at(18, SelLock, 0, 1'b0, "extlock_pre");
    expect_at(19, SelLock, 0, 1'b1, "extlock_rise");

    // Write ch1 div=8 phase=3 on edge 23
    wait_until(22);
    do_write(1, 8, 3);
    expect_at(23, SelLock, 0, 1'b0, "extlock_drop");
    expect_at(23, SelErr, 0, 1'b0, "cfg_err_valid");
    expect_at(38, SelLock, 0, 1'b0, "extlock_settle");
    expect_at(39, SelLock, 0, 1'b1, "extlock_relock");
    for (int n = 24; n <= 43; n++)
      expect_ch(n, 1, ((n - 24) % 8) == 3, ((n - 24) % 8) < 4);
    for (int n = 23; n <= 43; n++)
      expect_ch(n, 0, ((n - 4) % 5) == 0, ((n - 4) % 5) < 2);

    // Write to non-existent channel 6 on edge 41
    wait_until(40);
    do_write(6, 2, 0);
    expect_at(41, SelErr, 0, 1'b1, "cfg_err_pulse");
    expect_at(42, SelErr, 0, 1'b0, "cfg_err_end");
    expect_at(41, SelLock, 0, 1'b1, "extlock_keep0");
    expect_at(42, SelLock, 0, 1'b1, "extlock_keep1");
    for (int n = 44; n <= 45; n++) begin
      expect_ch(n, 0, ((n - 4) % 5) == 0, ((n - 4) % 5) < 2);
      expect_ch(n, 1, ((n - 24) % 8) == 3, ((n - 24) % 8) < 4);
    end

    // ch3 div=0 phase=9 on edge 46 -> period 1
    wait_until(45);
    do_write(3, 0, 9);
    expect_at(46, SelLock, 0, 1'b0, "extlock_p1");
    expect_at(61, SelLock, 0, 1'b0, "extlock_pre_race");
    for (int n = 47; n <= 56; n++) expect_ch(n, 3, 1'b1, 1'b0);

    // Write on the would-be locking edge 62, then disable ch2 for 3 edges
    wait_until(61);
    do_write(0, 6, 2);
    ch_enable[2] = 1'b0;
    expect_at(62, SelLock, 0, 1'b0, "extlock_race");
    expect_at(77, SelLock, 0, 1'b0, "extlock_race_settle");
    expect_at(78, SelLock, 0, 1'b1, "extlock_race_lock");
    for (int n = 63; n <= 65; n++) expect_ch(n, 2, 1'b0, 1'b0);
    for (int n = 66; n <= 75; n++)
      expect_ch(n, 2, ((n - 66) % 5) == 0, ((n - 66) % 5) < 2);
    for (int n = 63; n <= 75; n++)
      expect_ch(n, 0, ((n - 63) % 6) == 2, ((n - 63) % 6) < 3);
    wait_edge();
    wait_edge();
    wait_edge();
    ch_enable[2] = 1'b1;

    // One-cycle reset on edge 81 discards all configuration
    wait_until(80);
    reset = 1'b1;
    expect_at(80, SelReady, 0, 1'b0, "cfg_ready_midrst");
    wait_edge();
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) expect_ch(81, c, 1'b0, 1'b0);
    expect_at(81, SelLock, 0, 1'b0, "extlock_midrst");
    expect_at(81, SelErr, 0, 1'b0, "cfg_err_midrst");
    for (int n = 82; n <= 96; n++)
      for (int c = 0; c < NUM_CH; c++)
        expect_ch(n, c, ((n - 82) % 5) == 0, ((n - 82) % 5) < 2);
    expect_at(96, SelLock, 0, 1'b0, "extlock_rst2_pre");
    expect_at(97, SelLock, 0, 1'b1, "extlock_rst2_rise");

    for (int k = 0; k < 200 && sb.size() > 0; k++) wait_edge();
    if (sb.size() > 0) begin
      total++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
    end
    @(negedge refclk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of output channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 8: width of the divisor, phase and per-channel counter.
REQ-003 Parameter DEF_DIV, default 5: divisor loaded into every channel at reset.
REQ-004 Parameter DEF_PHASE, default 0: phase loaded into every channel at reset.
REQ-005 Parameter LOCK_CYCLES, default 16: settle length in refclk cycles, minimum 1.
REQ-006 refclk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ch_enable  in  NUM_CH  per-channel run enable.
REQ-009 cfg_valid  in  1  configuration write request.
REQ-010 cfg_ready  out  1  configuration write can be accepted.
REQ-011 cfg_ch  in  3  target channel index.
REQ-012 cfg_div  in  CNT_W  new divisor.
REQ-013 cfg_phase  in  CNT_W  new phase.
REQ-014 cfg_err  out  1  one-cycle pulse when a write addresses a channel that does not exist.
REQ-015 clk_en  out  NUM_CH  per-channel one-cycle strobe, once per period.
REQ-016 clk_div_out  out  NUM_CH  per-channel divided square wave.
REQ-017 extlock  out  1  all channel configurations have settled.

Function
REQ-018 Effective period per channel SHALL be P = max(div,1); effective phase SHALL be Ph = min(phase, P-1).
REQ-019 Per-channel counter SHALL count 0..P-1 and wrap to 0 on the cycle after P-1.
REQ-020 Registered clk_en[i] SHALL be high for one cycle when ch_enable[i]=1 and counter==Ph, giving exactly one pulse every P cycles.
REQ-021 Registered clk_div_out[i] SHALL be high when ch_enable[i]=1 and counter < P>>1, otherwise low.
REQ-022 For P=1, clk_en SHALL be continuously high and clk_div_out continuously low.
REQ-023 When ch_enable[i]=0, counter[i] SHALL be held at 0, and clk_en[i] and clk_div_out[i] SHALL be 0 on the next cycle.
REQ-024 Re-enabling a channel SHALL restart its counter from 0.
REQ-025 cfg_ready SHALL equal NOT reset; a write SHALL be accepted on any edge where cfg_valid and cfg_ready are both 1.
REQ-026 On an accepted write with cfg_ch < NUM_CH, the target channel SHALL load cfg_div and cfg_phase and reset its counter to 0 on that edge; other channels are unaffected.
REQ-027 On an accepted write with cfg_ch >= NUM_CH, no state SHALL change and cfg_err SHALL pulse for one cycle.
REQ-028 Lock FSM SHALL have two states. SETTLE: lock_cnt increments each cycle, and the FSM enters LOCKED when lock_cnt==LOCK_CYCLES-1. LOCKED: holds.
REQ-029 extlock SHALL be 1 exactly when the FSM is in LOCKED.
REQ-030 A valid accepted write SHALL force the FSM to SETTLE with lock_cnt=0, from either state; extlock is low on the following cycle.
REQ-031 A write that coincides with the SETTLE-to-LOCKED transition SHALL win: the FSM stays in SETTLE and lock_cnt is cleared to 0.
REQ-032 Back-to-back writes SHALL each restart the settle count.
REQ-033 Settle time SHALL be independent of ch_enable.

Reset
REQ-034 While reset=1: all counters SHALL be 0, every div=DEF_DIV and phase=DEF_PHASE, the FSM SHALL be in SETTLE with lock_cnt=0, and clk_en, clk_div_out, extlock and cfg_err SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard all runtime configuration on that edge.
REQ-036 extlock SHALL rise on the LOCK_CYCLES-th rising edge after reset deasserts.

Verification
REQ-037 Defaults with all channels enabled, after reset release -> clk_en pulses every 5 cycles, starting 1 cycle after release; clk_div_out is 2 high / 3 low; extlock rises on edge 16.
REQ-038 Locked, write ch1 div=8 phase=3 -> extlock low next cycle; ch1 clk_en occurs at counts 3, 11, 19...; clk_div_out is 4 high / 4 low; extlock high again 16 cycles after the write.
REQ-039 Write cfg_ch=6 with NUM_CH=4 -> cfg_err is a one-cycle pulse; extlock and all channels are unchanged.
REQ-040 Write div=0 phase=9 -> P=1; clk_en is constantly high and clk_div_out is constantly low.
REQ-041 Write on the cycle lock_cnt==15, then deassert ch_enable[2] for 3 cycles -> extlock stays low for 16 further cycles; ch2 outputs are 0 and ch2 restarts from count 0.
REQ-042 Reset pulse of 1 cycle mid-run after reconfiguration -> all channels return to div=5, and extlock is low for 16 cycles.
